ibex_fetch_align_fifo: RTL and testbench
========================================

Name: ibex_fetch_align_fifo

Overview:
- Sits between the instruction-bus response path and the IF stage's prefetch/fetch interface.
- Buffers 32-bit fetch words in a small FIFO and tracks the current fetch PC.
- Realigns 16/32-bit instructions across word boundaries and presents one instruction per handshake, together with its PC, next PC and error flags.
- Upstream uses busy_o to throttle outstanding bus requests; a branch/flush clears the FIFO and reloads the PC.

Parameters:
DEPTH, 3, number of 32-bit word entries (min 2).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clear_i  in  1  flush all entries, load PC from clear_addr_i
clear_addr_i  in  32  new fetch PC on clear; bit0 ignored
in_valid_i  in  1  bus response word valid (no ready; upstream honours busy_o)
in_rdata_i  in  32  bus response word
in_err_i  in  1  bus error for this word
out_valid_o  out  1  complete instruction available
out_ready_i  in  1  consumer accepts instruction
out_rdata_o  out  32  instruction (lower 16 meaningful if compressed)
out_addr_o  out  32  PC of out_rdata_o
out_addr_next_o  out  32  PC of following instruction
out_err_o  out  1  instruction affected by fetch error
out_err_plus2_o  out  1  error lies in second halfword only
busy_o  out  1  count >= DEPTH-1; upstream must not issue new requests

Behaviour:
- Reset (async, rst_i=1): count=0, pc_q=0, all entry data/err=0; out_valid_o=0, out_addr_o=0, out_addr_next_o=2, out_rdata_o=0, out_err_o=0, out_err_plus2_o=0, busy_o=0.
- Storage: entry0 is oldest. A push writes at index count (after any pop the same cycle). Push with count==DEPTH and no pop is illegal; an assertion fires.
- Alignment from pc_q[1]:
  - Aligned (pc_q[1]=0): instr = entry0. Compressed iff entry0[1:0]!=2'b11. Valid iff count>=1. err = entry0.err, plus2=0.
  - Unaligned, compressed (entry0[17:16]!=2'b11): instr = {16'h0, entry0[31:16]}. Valid iff count>=1. err = entry0.err.
  - Unaligned, uncompressed: instr = {entry1[15:0], entry0[31:16]}.
    - entry0.err=1: valid with count>=1, err=1, plus2=0.
    - Otherwise: valid iff count>=2; err = entry1.err, plus2 = entry1.err.
  - An entry0.err with unaligned compressed decode still presents as a single-halfword instruction.
- out_addr_o = pc_q. out_addr_next_o = pc_q + (compressed ? 2 : 4), 32-bit wrap (0xFFFFFFFE+2=0).
- Pop (out_valid_o & out_ready_i): pc_q <= out_addr_next_o.
  - Aligned compressed: no word freed.
  - Aligned uncompressed, or any unaligned instruction: entry0 freed, entries shift down.
- Simultaneous push and pop: count unchanged; new word lands behind the shifted data.
- clear_i has highest priority. Next cycle: count=0, pc_q={clear_addr_i[31:1],1'b0}, out_valid_o=0. in_valid_i and any pop in the clear cycle are discarded.
- Latency: a word pushed in cycle N makes out_valid_o high in N+1 at the earliest.
- out_* are held stable while out_valid_o=1 and out_ready_i=0, except across clear_i.
- Data outputs are don't-care while out_valid_o=0, but must not be X after reset.

Optional Feature:
- Macro: IBEX_FETCH_FIFO_BYPASS_EN.
- Defined: when count==0 (after pop), an in_valid_i word is presented combinationally the same cycle if it alone completes an instruction (aligned, or unaligned compressed/err). If popped that cycle it is not stored, except when an aligned compressed instruction leaves the upper half pending, in which case the word is stored.
- Undefined: strictly one-cycle latency; no in→out combinational path.

Test Plan:
- Reset mid-operation: count=2, assert rst_i -> out_valid_o=0, out_addr_o=0, busy_o=0 immediately (async).
- clear_addr=0x100, push 0x00B30293, 0x4501_4105 -> out 0x00B30293 @0x100 next 0x104; then 0x4105 @0x104 next 0x106; then 0x4501 @0x106 next 0x108, entry freed.
- clear_addr=0x202, push 0x0293_xxxx; hold 3 cycles -> out_valid_o=0. Push 0xxxxx_00B3 -> out 0x00B30293 @0x202 next 0x206, count=1.
- Unaligned split with second-word error: clear 0x302, push 0x0293_0000 (err=0), 0x0000_00B3 (err=1) -> out_valid_o=1, err=1, plus2=1.
- DEPTH=3, three pushes without ready -> busy_o=1 at count=2; fourth push with pop accepted, count stays 3. clear_i with in_valid_i=1 -> count=0, word dropped.
- Bypass build: clear 0x400 then push 0x4105_4105 with ready=1 -> out_valid_o=1 same cycle, addr 0x400; without macro, first seen at N+1.

Source files
------------

// File: rtl/ibex_fetch_align_fifo.sv
// Fetch FIFO with 16/32-bit instruction realignment across word boundaries.
// Define IBEX_FETCH_FIFO_BYPASS_EN to let an incoming word reach the outputs in the same cycle when empty.
module ibex_fetch_align_fifo #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [31:0] clear_addr_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic [31:0] out_addr_next_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] err_q, err_d;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      pc_q, pc_d;

  logic        bypass;
  logic [31:0] head0;
  logic        head0_err;
  logic        has_one, has_two;
  logic        aligned, compressed;
  logic        pop, pop_free;
  logic        unused_clear_lsb;

  assign unused_clear_lsb = clear_addr_i[0];

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
  assign bypass = in_valid_i && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  // When bypassing, the incoming word stands in for an empty entry0.
  assign head0     = bypass ? in_rdata_i : data_q[0];
  assign head0_err = bypass ? in_err_i : err_q[0];
  assign has_one   = bypass || (count_q != '0);
  assign has_two   = !bypass && (count_q >= CW'(2));
  assign aligned   = ~pc_q[1];

  always_comb begin
    compressed      = 1'b0;
    out_rdata_o     = head0;
    out_valid_o     = has_one;
    out_err_o       = head0_err;
    out_err_plus2_o = 1'b0;
    if (aligned) begin
      compressed = (head0[1:0] != 2'b11);
    end else if (head0[17:16] != 2'b11) begin
      compressed  = 1'b1;
      out_rdata_o = {16'h0, head0[31:16]};
    end else begin
      out_rdata_o = {data_q[1][15:0], head0[31:16]};
      // A faulty first half completes the instruction without waiting for entry1.
      if (!head0_err) begin
        out_valid_o     = has_two;
        out_err_o       = err_q[1];
        out_err_plus2_o = err_q[1];
      end
    end
  end

  assign out_addr_o      = pc_q;
  assign out_addr_next_o = pc_q + (compressed ? 32'd2 : 32'd4);
  assign busy_o          = (count_q >= CW'(DEPTH - 1));

  assign pop      = out_valid_o & out_ready_i;
  assign pop_free = ~(aligned & compressed);

  always_comb begin
    data_d  = data_q;
    err_d   = err_q;
    count_d = count_q;
    pc_d    = pc_q;
    if (clear_i) begin
      count_d = '0;
      pc_d    = {clear_addr_i[31:1], 1'b0};
    end else begin
      if (pop) begin
        pc_d = out_addr_next_o;
      end
      if (pop && pop_free && !bypass) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          data_d[i] = data_q[i+1];
          err_d[i]  = err_q[i+1];
        end
        count_d = count_q - CW'(1);
      end
      // A bypassed word that was fully consumed is never stored.
      if (in_valid_i && !(bypass && pop && pop_free) && (count_d < CW'(DEPTH))) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (count_d == CW'(i)) begin
            data_d[i] = in_rdata_i;
            err_d[i]  = in_err_i;
          end
        end
        count_d = count_d + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      err_q   <= '0;
      count_q <= '0;
      pc_q    <= '0;
    end else begin
      data_q  <= data_d;
      err_q   <= err_d;
      count_q <= count_d;
      pc_q    <= pc_d;
    end
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(in_valid_i && !clear_i && (count_q == CW'(DEPTH)) && !(pop && pop_free)));

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// Directed self-checking bench for ibex_fetch_align_fifo (DEPTH=3).
module tb_ibex_fetch_align_fifo;

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk_i;
  logic        rst_i;
  logic        clear_i;
  logic [31:0] clear_addr_i;
  logic        in_valid_i;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic [31:0] out_addr_next_o;
  logic        out_err_o;
  logic        out_err_plus2_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  ibex_fetch_align_fifo #(.DEPTH(3)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (clear_i),
    .clear_addr_i    (clear_addr_i),
    .in_valid_i      (in_valid_i),
    .in_rdata_i      (in_rdata_i),
    .in_err_i        (in_err_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_rdata_o     (out_rdata_o),
    .out_addr_o      (out_addr_o),
    .out_addr_next_o (out_addr_next_o),
    .out_err_o       (out_err_o),
    .out_err_plus2_o (out_err_plus2_o),
    .busy_o          (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic [31:0] caddr, input logic vld,
                               input logic [31:0] data, input logic err, input logic rdy);
    clear_i      = clr;
    clear_addr_i = caddr;
    in_valid_i   = vld;
    in_rdata_i   = data;
    in_err_i     = err;
    out_ready_i  = rdy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rdy);
  endtask

  task automatic push(input logic [31:0] data, input logic err);
    applyStimulus(1'b0, 32'h0, 1'b1, data, err, 1'b0);
    tick();
  endtask

  task automatic flush(input logic [31:0] addr);
    applyStimulus(1'b1, addr, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  logic [31:0] drain_data [3];
  logic [31:0] drain_addr [3];

  initial begin
    rst_i = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_valid", 32'(out_valid_o), 32'h0);
    checkOutput("rst_addr", out_addr_o, 32'h0);
    checkOutput("rst_next", out_addr_next_o, 32'h2);
    checkOutput("rst_rdata", out_rdata_o, 32'h0);
    checkOutput("rst_err", {30'h0, out_err_o, out_err_plus2_o}, 32'h0);
    checkOutput("rst_busy", 32'(busy_o), 32'h0);
    #2 rst_i = 1'b0;

    // Aligned 32-bit then two compressed halves of one word
    flush(32'h100);
    idle(1'b0);
    checkOutput("clr_valid", 32'(out_valid_o), 32'h0);
    checkOutput("clr_addr", out_addr_o, 32'h100);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h00B30293, 1'b0, 1'b0);
    checkOutput("lat_valid", 32'(out_valid_o), 32'(BYP));
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h45014105, 1'b0, 1'b0);
    checkOutput("a32_valid", 32'(out_valid_o), 32'h1);
    checkOutput("a32_rdata", out_rdata_o, 32'h00B30293);
    checkOutput("a32_addr", out_addr_o, 32'h100);
    checkOutput("a32_next", out_addr_next_o, 32'h104);
    tick();
    idle(1'b1);
    checkOutput("two_busy", 32'(busy_o), 32'h1);
    checkOutput("hold_rdata", out_rdata_o, 32'h00B30293);
    tick();
    checkOutput("c0_rdata", {16'h0, out_rdata_o[15:0]}, 32'h4105);
    checkOutput("c0_addr", out_addr_o, 32'h104);
    checkOutput("c0_next", out_addr_next_o, 32'h106);
    checkOutput("c0_busy", 32'(busy_o), 32'h0);
    tick();
    checkOutput("c1_rdata", out_rdata_o, 32'h00004501);
    checkOutput("c1_addr", out_addr_o, 32'h106);
    checkOutput("c1_next", out_addr_next_o, 32'h108);
    tick();
    idle(1'b0);
    checkOutput("c1_freed", 32'(out_valid_o), 32'h0);
    checkOutput("c1_pc", out_addr_o, 32'h108);

    // Unaligned 32-bit instruction split over two words
    flush(32'h202);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h02930000, 1'b0, 1'b0);
    checkOutput("split_push_valid", 32'(out_valid_o), 32'h0);
    tick();
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("split_hold", 32'(out_valid_o), 32'h0);
      tick();
    end
    push(32'h000000B3, 1'b0);
    idle(1'b1);
    checkOutput("split_valid", 32'(out_valid_o), 32'h1);
    checkOutput("split_rdata", out_rdata_o, 32'h00B30293);
    checkOutput("split_addr", out_addr_o, 32'h202);
    checkOutput("split_next", out_addr_next_o, 32'h206);
    checkOutput("split_err", 32'(out_err_o), 32'h0);
    tick();
    idle(1'b0);
    checkOutput("split_left_valid", 32'(out_valid_o), 32'h1);
    checkOutput("split_left_addr", out_addr_o, 32'h206);
    checkOutput("split_left_next", out_addr_next_o, 32'h208);
    checkOutput("split_left_busy", 32'(busy_o), 32'h0);

    // Error in the second halfword only
    flush(32'h302);
    push(32'h02930000, 1'b0);
    push(32'h000000B3, 1'b1);
    idle(1'b0);
    checkOutput("e2_valid", 32'(out_valid_o), 32'h1);
    checkOutput("e2_err", 32'(out_err_o), 32'h1);
    checkOutput("e2_plus2", 32'(out_err_plus2_o), 32'h1);
    checkOutput("e2_rdata", out_rdata_o, 32'h00B30293);
    checkOutput("e2_next", out_addr_next_o, 32'h306);

    // Error in the first word completes the instruction alone
    flush(32'h602);
    push(32'h02930000, 1'b1);
    idle(1'b0);
    checkOutput("e1_valid", 32'(out_valid_o), 32'h1);
    checkOutput("e1_err", 32'(out_err_o), 32'h1);
    checkOutput("e1_plus2", 32'(out_err_plus2_o), 32'h0);
    checkOutput("e1_next", out_addr_next_o, 32'h606);

    // Fill to DEPTH, then push alongside a pop
    flush(32'h0);
    push(32'h00100013, 1'b0);
    idle(1'b0);
    checkOutput("fill1_busy", 32'(busy_o), 32'h0);
    push(32'h00200013, 1'b0);
    idle(1'b0);
    checkOutput("fill2_busy", 32'(busy_o), 32'h1);
    push(32'h00300013, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h00400013, 1'b0, 1'b1);
    checkOutput("full_rdata", out_rdata_o, 32'h00100013);
    checkOutput("full_addr", out_addr_o, 32'h0);
    tick();
    drain_data = '{32'h00200013, 32'h00300013, 32'h00400013};
    drain_addr = '{32'h4, 32'h8, 32'hC};
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("drain_valid", 32'(out_valid_o), 32'h1);
      checkOutput("drain_rdata", out_rdata_o, drain_data[i]);
      checkOutput("drain_addr", out_addr_o, drain_addr[i]);
      tick();
    end
    checkOutput("drain_empty", 32'(out_valid_o), 32'h0);
    checkOutput("drain_pc", out_addr_o, 32'h10);

    // Clear beats a simultaneous push
    push(32'h00500013, 1'b0);
    applyStimulus(1'b1, 32'h501, 1'b1, 32'h00600013, 1'b0, 1'b0);
    tick();
    idle(1'b0);
    checkOutput("drop_valid", 32'(out_valid_o), 32'h0);
    checkOutput("drop_addr", out_addr_o, 32'h500);
    checkOutput("drop_busy", 32'(busy_o), 32'h0);
    tick();
    checkOutput("drop_hold", 32'(out_valid_o), 32'h0);

    // Next PC wraps at the top of the address space
    flush(32'hFFFFFFFE);
    push(32'h00000001, 1'b0);
    idle(1'b0);
    checkOutput("wrap_valid", 32'(out_valid_o), 32'h1);
    checkOutput("wrap_addr", out_addr_o, 32'hFFFFFFFE);
    checkOutput("wrap_next", out_addr_next_o, 32'h0);
    checkOutput("wrap_rdata", out_rdata_o, 32'h0);

    // Same-cycle presentation only in the bypass build
    flush(32'h400);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h41054105, 1'b0, 1'b1);
    checkOutput("byp_valid", 32'(out_valid_o), 32'(BYP));
    checkOutput("byp_addr", out_addr_o, 32'h400);
    tick();
    idle(1'b0);
    checkOutput("byp_next_valid", 32'(out_valid_o), 32'h1);
    checkOutput("byp_next_addr", out_addr_o, BYP ? 32'h402 : 32'h400);

    // Asynchronous reset mid-operation
    flush(32'h0);
    push(32'h00100013, 1'b0);
    push(32'h00200013, 1'b0);
    idle(1'b0);
    checkOutput("pre_rst_busy", 32'(busy_o), 32'h1);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(out_valid_o), 32'h0);
    checkOutput("arst_addr", out_addr_o, 32'h0);
    checkOutput("arst_busy", 32'(busy_o), 32'h0);
    #3 rst_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
